// File: rtl/bus_pattern_master.sv
// rtl/bus_pattern_master.sv - LFSR write pass then read-back check pass over a valid/ready bus
// Heartbeat LED runs free of the transfer FSM.
module bus_pattern_master #(
  parameter int                 ADDR_W    = 4,
  parameter int                 DATA_W    = 8,
  parameter int                 NUM_TXN   = 4,
  parameter logic [ADDR_W-1:0]  BASE_ADDR = 4'hB,
  parameter logic [DATA_W-1:0]  SEED      = 8'h1A,
  parameter logic [DATA_W-1:0]  POLY      = 8'hB8,
  parameter int                 TIMEOUT   = 16,
  parameter int                 HB_DIV    = 25
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              valid,
  input  logic              ready,
  output logic              write,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] write_data,
  input  logic [DATA_W-1:0] read_data,
  input  logic              rd_valid,
  output logic              busy,
  output logic              done,
  output logic [15:0]       err_count,
  output logic              led
);

  localparam int                WAIT_W   = $clog2(TIMEOUT + 1);
  localparam int                HB_W     = $clog2(HB_DIV + 1);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_TXN - 1);
  localparam logic [WAIT_W-1:0] TO_LAST  = WAIT_W'(TIMEOUT - 1);
  localparam logic [HB_W-1:0]   HB_LAST  = HB_W'(HB_DIV - 1);

  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_DATA, S_RESP, S_FIN} state_t;

  state_t            r_state;
  logic              r_pass;
  logic [ADDR_W-1:0] r_idx;
  logic [DATA_W-1:0] r_lfsr;
  logic [WAIT_W-1:0] r_wait;
  logic              r_valid;
  logic              r_write;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic              r_busy;
  logic              r_done;
  logic [15:0]       r_err;
  logic [HB_W-1:0]   r_hb_cnt;
  logic              r_led;

  logic [DATA_W-1:0] w_lfsr_next;
  logic [ADDR_W-1:0] w_addr_next;
  logic [15:0]       w_err_inc;
  logic              w_last;
  logic              w_resp_event;
  logic              w_resp_bad;

  assign w_lfsr_next  = (r_lfsr >> 1) ^ (r_lfsr[0] ? POLY : '0);
  assign w_addr_next  = BASE_ADDR + r_idx + ADDR_W'(1);
  assign w_err_inc    = (r_err == 16'hFFFF) ? r_err : r_err + 16'd1;
  assign w_last       = (r_idx >= LAST_IDX);
  // A response arriving on the final wait cycle is still compared, not timed out.
  assign w_resp_event = rd_valid || (r_wait == TO_LAST);
  assign w_resp_bad   = rd_valid ? (read_data != r_lfsr) : 1'b1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_pass  <= 1'b0;
      r_idx   <= '0;
      r_lfsr  <= SEED;
      r_wait  <= '0;
      r_valid <= 1'b0;
      r_write <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_idx   <= '0;
            r_pass  <= 1'b0;
            r_lfsr  <= SEED;
            r_err   <= '0;
            r_valid <= 1'b1;
            r_write <= 1'b1;
            r_addr  <= BASE_ADDR;
            r_wdata <= SEED;
            r_busy  <= 1'b1;
            r_state <= S_ADDR;
          end
        end
        S_ADDR: begin
          if (ready) r_state <= S_DATA;
        end
        S_DATA: begin
          if (ready) begin
            if (!r_pass) begin
              r_state <= S_ADDR;
              if (!w_last) begin
                r_idx   <= r_idx + ADDR_W'(1);
                r_addr  <= w_addr_next;
                r_lfsr  <= w_lfsr_next;
                r_wdata <= w_lfsr_next;
              end else begin
                // Switch to the read pass, replaying the sequence from the seed.
                r_pass  <= 1'b1;
                r_idx   <= '0;
                r_lfsr  <= SEED;
                r_addr  <= BASE_ADDR;
                r_write <= 1'b0;
              end
            end else begin
              r_valid <= 1'b0;
              r_wait  <= '0;
              r_state <= S_RESP;
            end
          end
        end
        S_RESP: begin
          if (w_resp_event) begin
            if (w_resp_bad) r_err <= w_err_inc;
            r_lfsr <= w_lfsr_next;
            if (!w_last) begin
              r_idx   <= r_idx + ADDR_W'(1);
              r_addr  <= w_addr_next;
              r_valid <= 1'b1;
              r_state <= S_ADDR;
            end else begin
              r_done  <= 1'b1;
              r_state <= S_FIN;
            end
          end else begin
            r_wait <= r_wait + WAIT_W'(1);
          end
        end
        S_FIN: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_hb_cnt <= '0;
      r_led    <= 1'b0;
    end else if (r_hb_cnt == HB_LAST) begin
      r_hb_cnt <= '0;
      r_led    <= ~r_led;
    end else begin
      r_hb_cnt <= r_hb_cnt + HB_W'(1);
    end
  end

  assign valid      = r_valid;
  assign write      = r_write;
  assign addr       = r_addr;
  assign write_data = r_wdata;
  assign busy       = r_busy;
  assign done       = r_done;
  assign err_count  = r_err;
  assign led        = r_led;

endmodule

// File: tb/tb_bus_pattern_master.sv
// tb/tb_bus_pattern_master.sv - directed bench for bus_pattern_master (default and NUM_TXN=6 instances)
`timescale 1ns/1ps
module tb_bus_pattern_master;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic       ready = 1'b0;
  logic       rd_valid = 1'b0;
  logic [7:0] read_data = 8'h00;
  logic       sel = 1'b0;

  logic       a_valid, a_write, a_busy, a_done, a_led;
  logic [3:0] a_addr;
  logic [7:0] a_wd;
  logic [15:0] a_err;
  logic       b_valid, b_write, b_busy, b_done, b_led;
  logic [3:0] b_addr;
  logic [7:0] b_wd;
  logic [15:0] b_err;

  logic       m_valid, m_write, m_busy, m_done, m_led;
  logic [3:0] m_addr;
  logic [7:0] m_wd;
  logic [15:0] m_err;

  int tests = 0;
  int fails = 0;
  int done_cnt = 0;
  logic [7:0] mem [16];
  logic [7:0] wd_tab [6] = '{8'h1A, 8'h0D, 8'hBE, 8'h5F, 8'h97, 8'hF3};

  always #5 clk = ~clk;

  bus_pattern_master u_dut (
    .clk(clk), .reset(reset), .start(start & ~sel), .valid(a_valid), .ready(ready),
    .write(a_write), .addr(a_addr), .write_data(a_wd), .read_data(read_data),
    .rd_valid(rd_valid), .busy(a_busy), .done(a_done), .err_count(a_err), .led(a_led)
  );

  bus_pattern_master #(.NUM_TXN(6)) u_dut6 (
    .clk(clk), .reset(reset), .start(start & sel), .valid(b_valid), .ready(ready),
    .write(b_write), .addr(b_addr), .write_data(b_wd), .read_data(read_data),
    .rd_valid(rd_valid), .busy(b_busy), .done(b_done), .err_count(b_err), .led(b_led)
  );

  assign m_valid = sel ? b_valid : a_valid;
  assign m_write = sel ? b_write : a_write;
  assign m_busy  = sel ? b_busy  : a_busy;
  assign m_done  = sel ? b_done  : a_done;
  assign m_led   = sel ? b_led   : a_led;
  assign m_addr  = sel ? b_addr  : a_addr;
  assign m_wd    = sel ? b_wd    : a_wd;
  assign m_err   = sel ? b_err   : a_err;

  always @(posedge clk) if (m_done) done_cnt <= done_cnt + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_valid"}, 32'(m_valid), 32'd0);
    chk({tag, "_write"}, 32'(m_write), 32'd0);
    chk({tag, "_addr"},  32'(m_addr),  32'd0);
    chk({tag, "_wdata"}, 32'(m_wd),    32'd0);
    chk({tag, "_busy"},  32'(m_busy),  32'd0);
    chk({tag, "_done"},  32'(m_done),  32'd0);
    chk({tag, "_err"},   32'(m_err),   32'd0);
    chk({tag, "_led"},   32'(m_led),   32'd0);
  endtask

  task automatic start_run();
    chk("pre_start_busy", 32'(m_busy), 32'd0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("start_busy", 32'(m_busy), 32'd1);
    chk("start_valid", 32'(m_valid), 32'd1);
  endtask

  // mode: 0 echo, 1 corrupted echo, 2 no response
  task automatic xfer(input logic [3:0] a, input logic w, input logic [7:0] wd,
                      input int stall, input int mode);
    int cnt;
    chk("addr", 32'(m_addr), 32'(a));
    chk("write", 32'(m_write), 32'(w));
    chk("addr_valid", 32'(m_valid), 32'd1);
    for (int i = 0; i < stall; i++) begin
      ready = 1'b0;
      @(negedge clk);
      chk("stall_addr", 32'(m_addr), 32'(a));
      chk("stall_valid", 32'(m_valid), 32'd1);
      if (w) chk("stall_wdata", 32'(m_wd), 32'(wd));
    end
    ready = 1'b1;
    @(negedge clk);
    chk("data_addr", 32'(m_addr), 32'(a));
    chk("data_valid", 32'(m_valid), 32'd1);
    if (w) begin
      chk("data_wdata", 32'(m_wd), 32'(wd));
      mem[a] = m_wd;
    end
    @(negedge clk);
    if (!w) begin
      chk("resp_valid", 32'(m_valid), 32'd0);
      if (mode == 2) begin
        cnt = 0;
        while (m_busy && !m_valid && !m_done && cnt < 40) begin
          cnt++;
          @(negedge clk);
        end
        chk("timeout_cycles", 32'(cnt), 32'd16);
      end else begin
        @(negedge clk);
        rd_valid = 1'b1;
        read_data = mem[a] ^ ((mode == 1) ? 8'hFF : 8'h00);
        @(negedge clk);
        rd_valid = 1'b0;
      end
    end
  endtask

  initial begin
    logic [3:0] a;
    int base;
    int rd_modes [4] = '{0, 0, 1, 2};

    @(negedge clk);
    check_reset_outputs("rst");
    reset = 1'b1;

    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      chk($sformatf("led_c%0d", k), 32'(m_led), 32'((k / 25) % 2));
    end

    // Run A: write pass, echo read pass, start pulses during the run ignored
    base = done_cnt;
    ready = 1'b1;
    start_run();
    for (int i = 0; i < 4; i++) begin
      if (i == 1) start = 1'b1;
      if (i == 3) start = 1'b0;
      a = 4'hB + 4'(i);
      xfer(a, 1'b1, wd_tab[i], 0, 0);
    end
    for (int i = 0; i < 4; i++) begin
      a = 4'hB + 4'(i);
      xfer(a, 1'b0, 8'h00, 0, 0);
    end
    chk("a_done", 32'(m_done), 32'd1);
    chk("a_err", 32'(m_err), 32'd0);
    @(negedge clk);
    chk("a_done_low", 32'(m_done), 32'd0);
    chk("a_idle_busy", 32'(m_busy), 32'd0);
    chk("a_idle_valid", 32'(m_valid), 32'd0);
    chk("a_done_pulses", 32'(done_cnt - base), 32'd1);

    // Run B: corrupt read at D, no answer at E
    start_run();
    for (int i = 0; i < 4; i++) begin
      a = 4'hB + 4'(i);
      xfer(a, 1'b1, wd_tab[i], 0, 0);
    end
    for (int i = 0; i < 4; i++) begin
      a = 4'hB + 4'(i);
      xfer(a, 1'b0, 8'h00, 0, rd_modes[i]);
      if (i == 2) chk("b_err_after_d", 32'(m_err), 32'd1);
    end
    chk("b_done", 32'(m_done), 32'd1);
    chk("b_err", 32'(m_err), 32'd2);
    repeat (3) @(negedge clk);
    chk("b_err_hold", 32'(m_err), 32'd2);
    chk("b_idle_busy", 32'(m_busy), 32'd0);

    // Run C: NUM_TXN=6 instance, address wrap and 3-cycle ADDR stalls
    sel = 1'b1;
    @(negedge clk);
    start_run();
    for (int i = 0; i < 6; i++) begin
      a = 4'hB + 4'(i);
      xfer(a, 1'b1, wd_tab[i], 3, 0);
    end
    for (int i = 0; i < 6; i++) begin
      a = 4'hB + 4'(i);
      xfer(a, 1'b0, 8'h00, 3, 0);
    end
    chk("c_done", 32'(m_done), 32'd1);
    chk("c_err", 32'(m_err), 32'd0);
    @(negedge clk);
    chk("c_idle_busy", 32'(m_busy), 32'd0);
    sel = 1'b0;
    ready = 1'b1;
    @(negedge clk);

    // Run D: reset during DATA phase of the second read
    base = done_cnt;
    start_run();
    chk("d_err_cleared", 32'(m_err), 32'd0);
    for (int i = 0; i < 4; i++) begin
      a = 4'hB + 4'(i);
      xfer(a, 1'b1, wd_tab[i], 0, 0);
    end
    xfer(4'hB, 1'b0, 8'h00, 0, 0);
    chk("d_addr_c", 32'(m_addr), 32'hC);
    @(negedge clk);
    chk("d_data_valid", 32'(m_valid), 32'd1);
    #1 reset = 1'b0;
    #1 check_reset_outputs("async_rst");
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (5) @(negedge clk);
    chk("d_idle_busy", 32'(m_busy), 32'd0);
    chk("d_idle_valid", 32'(m_valid), 32'd0);
    chk("d_no_done", 32'(done_cnt - base), 32'd0);
    start_run();
    chk("d_restart_addr", 32'(m_addr), 32'hB);
    chk("d_restart_wdata", 32'(m_wd), 32'h1A);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/bus_pattern_master.md
BUS_PATTERN_MASTER -- requirements
Module: bus_pattern_master

Interface
REQ-001 The block SHALL provide these parameters, one per line (name, default, meaning):
- ADDR_W, 4: address width.
- DATA_W, 8: data width.
- NUM_TXN, 4: transfers per pass, legal range 1 to 2^ADDR_W.
- BASE_ADDR, 4'hB: first address.
- SEED, 8'h1A: LFSR seed, must be nonzero.
- POLY, 8'hB8: Galois LFSR tap mask.
- TIMEOUT, 16: maximum wait in cycles for read response.
- HB_DIV, 25: heartbeat half-period in cycles.
REQ-002 The block SHALL provide these ports, one per line (name, direction, width, meaning):
- clk, in, 1: clock.
- reset, in, 1: reset, asynchronous, active-low.
- start, in, 1: begin a run when sampled high in IDLE.
- valid, out, 1: bus request.
- ready, in, 1: slave accepts the current phase.
- write, out, 1: 1 = write, 0 = read.
- addr, out, ADDR_W: transfer address.
- write_data, out, DATA_W: write payload.
- read_data, in, DATA_W: read payload.
- rd_valid, in, 1: read_data is valid this cycle.
- busy, out, 1: high whenever the state is not IDLE.
- done, out, 1: one-cycle pulse at end of run.
- err_count, out, 16: count of read mismatches and timeouts.
- led, out, 1: heartbeat output.

Function
REQ-003 The FSM SHALL have states IDLE, ADDR, DATA, RESP and FIN, plus a pass flag (WR/RD) and an index counter idx.
REQ-004 IDLE SHALL drive valid=0; when start=1 it SHALL set idx=0, pass=WR, lfsr=SEED, clear err_count, and go to ADDR.
REQ-005 ADDR SHALL drive valid=1, addr=BASE_ADDR+idx (mod 2^ADDR_W, wrapping) and write=(pass==WR); the FSM SHALL hold in ADDR while ready=0 and go to DATA on valid&&ready.
REQ-006 DATA SHALL drive valid=1; in a WR pass it SHALL also drive write_data=lfsr, and addr/write SHALL stay stable until acceptance.
REQ-007 On DATA acceptance in a WR pass, the block SHALL advance lfsr (next = (lfsr>>1) ^ (lfsr[0] ? POLY : 0)) and go to the advance step.
REQ-008 On DATA acceptance in an RD pass, the FSM SHALL go to RESP with the wait counter cleared.
REQ-009 RESP SHALL drive valid=0. On rd_valid it SHALL compare read_data with lfsr, increment err_count on mismatch, advance lfsr, and go to the advance step.
REQ-010 In RESP, if TIMEOUT cycles elapse without rd_valid, the block SHALL increment err_count, advance lfsr, and go to the advance step. If rd_valid arrives in the same cycle the timeout expires, rd_valid SHALL win.
REQ-011 The advance step SHALL work as follows:
- If idx<NUM_TXN-1: idx++, next state ADDR.
- Else if pass==WR: pass=RD, idx=0, lfsr=SEED, next state ADDR.
- Else: next state FIN.
REQ-012 FIN SHALL pulse done=1 for exactly one cycle, then return to IDLE; err_count SHALL hold its value until the next start.
REQ-013 err_count SHALL saturate at 16'hFFFF.
REQ-014 start SHALL be ignored while busy=1.
REQ-015 With NUM_TXN=1, each pass SHALL perform exactly one transfer.
REQ-016 led SHALL toggle every HB_DIV clk cycles, independently of the FSM.

Reset
REQ-017 While reset=0, the block SHALL force: state=IDLE, valid=0, write=0, addr=0, write_data=0, busy=0, done=0, err_count=0, led=0, idx=0, lfsr=SEED, heartbeat counter=0.
REQ-018 Reset asserted mid-transfer SHALL abort immediately, with no done pulse; after release the block SHALL wait in IDLE for start.

Verification
REQ-019 Write pass: defaults, ready tied 1, one start pulse -> write transfers B/1A, C/0D, D/BE, E/5F; busy rises the cycle after start.
REQ-020 Read-back check: a slave model echoes the stored data with rd_valid 2 cycles after acceptance -> 4 reads to B..E, err_count=0, exactly one done pulse.
REQ-021 Mismatch and timeout: the slave corrupts the read at address D and never answers the read at address E -> err_count=2; E completes after 16 wait cycles.
REQ-022 Wrap and backpressure: NUM_TXN=6, ready low for 3 cycles in every ADDR phase -> addresses B,C,D,E,F,0; addr and write_data stable while stalled.
REQ-023 Reset and start-while-busy: reset=0 during the DATA phase of the second read -> all outputs at reset values asynchronously; a start pulse during a run has no effect.
REQ-024 Heartbeat: HB_DIV=25, 100 cycles -> led toggles at cycles 25, 50, 75 and 100.
